joy_dir_filter: RTL and testbench

Multi-player digital joystick conditioner placed between the keyboard/gamepad merge logic and the core input registers. Per player it:
- synchronises the raw direction bits
- debounces them
- applies screen-orientation rotation
- applies a selectable direction-arbitration mode: pass-through, 4-way last-wins with fallback, 8-way with opposite-cancel, or 4-way first-wins.
It is the parametrised successor of the single-player 4-way last-pressed filter.

---
 rtl/joy_pkg.sv | 51 +++++
 rtl/joy_debounce.sv | 55 +++++
 rtl/joy_dir_filter.sv | 108 ++++++++++
 tb/tb_joy_dir_filter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the multi-player joystick direction filter.
// Direction bit layout, mode/rotation encodings and helper functions.
package joy_pkg;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   typedef enum logic [1:0] {
      JOY_PASS       = 2'd0,
      JOY_4WAY_LAST  = 2'd1,
      JOY_8WAY       = 2'd2,
      JOY_4WAY_FIRST = 2'd3
   } joy_mode_e;

   typedef enum logic [1:0] {
      ROT_0   = 2'd0,
      ROT_90  = 2'd1,
      ROT_270 = 2'd2,
      ROT_180 = 2'd3
   } joy_rot_e;

   // Simultaneous events resolve as up > down > left > right.
   function automatic logic [3:0] pri_onehot(input logic [3:0] v);
      logic [3:0] r;
      r = '0;
      priority case (1'b1)
         v[DIR_UP]:    r[DIR_UP]    = 1'b1;
         v[DIR_DOWN]:  r[DIR_DOWN]  = 1'b1;
         v[DIR_LEFT]:  r[DIR_LEFT]  = 1'b1;
         v[DIR_RIGHT]: r[DIR_RIGHT] = 1'b1;
         default:      r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] rotate_dir(input logic [3:0] s,
                                             input logic [1:0] r);
      logic [3:0] d;
      unique case (joy_rot_e'(r))
         ROT_0:   d = s;
         ROT_90:  d = {s[DIR_LEFT], s[DIR_RIGHT], s[DIR_DOWN], s[DIR_UP]};
         ROT_270: d = {s[DIR_RIGHT], s[DIR_LEFT], s[DIR_UP], s[DIR_DOWN]};
         ROT_180: d = {s[DIR_DOWN], s[DIR_UP], s[DIR_RIGHT], s[DIR_LEFT]};
         default: d = s;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/joy_debounce.sv
// One 4-bit joystick channel: two-flop synchroniser plus per-bit
// tick-counting debounce producing the accepted (stable) level.
module joy_debounce
   import joy_pkg::*;
#(
   parameter int DB_TICKS = 3,
   parameter int DB_W     = 4
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ce,
   input  logic [3:0] raw,
   output logic [3:0] stable
);

   localparam logic [DB_W-1:0] LAST =
      (DB_TICKS == 0) ? '0 : DB_W'(DB_TICKS - 1);

   logic [3:0]      s1, s2, st_q;
   logic [DB_W-1:0] cnt [4];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Any matching cycle drops a partial count, so short glitches vanish.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st_q <= '0;
         for (int b = 0; b < 4; b++) cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (s2[b] == st_q[b]) begin
               cnt[b] <= '0;
            end else if (ce) begin
               if (cnt[b] == LAST) begin
                  st_q[b] <= s2[b];
                  cnt[b]  <= '0;
               end else begin
                  cnt[b] <= cnt[b] + 1'b1;
               end
            end
         end
      end
   end

   assign stable = (DB_TICKS == 0) ? s2 : st_q;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick conditioner: debounce, screen rotation and
// per-player direction arbitration with registered outputs.
module joy_dir_filter
   import joy_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int DB_TICKS    = 3,
   parameter int DB_W        = 4
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     ce,
   input  logic [1:0]               mode,
   input  logic [1:0]               rotate,
   input  logic [4*NUM_PLAYERS-1:0] dir_in,
   output logic [4*NUM_PLAYERS-1:0] dir_out,
   output logic [NUM_PLAYERS-1:0]   changed
);

   logic [1:0] mode_q, rot_q;
   logic       set_chg;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= '0;
         rot_q  <= '0;
      end else begin
         mode_q <= mode;
         rot_q  <= rotate;
      end
   end

   // A new setting wipes arbitration history so no stale mask survives.
   assign set_chg = (mode != mode_q) || (rotate != rot_q);

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
      logic [3:0] st, d, d_q, np;
      logic [3:0] mask_q, mask_nx, nx, out_q;
      logic       chg_q;

      joy_debounce #(
         .DB_TICKS (DB_TICKS),
         .DB_W     (DB_W)
      ) u_db (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .ce      (ce),
         .raw     (dir_in[4*p +: 4]),
         .stable  (st)
      );

      assign d  = rotate_dir(st, rotate);
      assign np = d & ~d_q;

      always_comb begin
         mask_nx = '0;
         nx      = d;
         unique case (joy_mode_e'(mode))
            JOY_PASS: nx = d;
            JOY_4WAY_LAST: begin
               mask_nx = mask_q;
               if (np != '0)
                  mask_nx = pri_onehot(np);
               else if ((d & mask_q) == '0 && d != '0)
                  mask_nx = pri_onehot(d);
               nx = d & mask_nx;
            end
            JOY_8WAY: begin
               if (d[DIR_UP] && d[DIR_DOWN]) begin
                  nx[DIR_UP]   = 1'b0;
                  nx[DIR_DOWN] = 1'b0;
               end
               if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
                  nx[DIR_LEFT]  = 1'b0;
                  nx[DIR_RIGHT] = 1'b0;
               end
            end
            JOY_4WAY_FIRST: begin
               mask_nx = ((d & mask_q) == '0) ? pri_onehot(d) : mask_q;
               nx      = d & mask_nx;
            end
            default: nx = d;
         endcase
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            d_q    <= '0;
            mask_q <= '0;
            out_q  <= '0;
            chg_q  <= 1'b0;
         end else if (set_chg) begin
            d_q    <= '0;
            mask_q <= '0;
            chg_q  <= 1'b0;
         end else begin
            d_q    <= d;
            mask_q <= mask_nx;
            out_q  <= nx;
            chg_q  <= (nx != out_q);
         end
      end

      assign dir_out[4*p +: 4] = out_q;
      assign changed[p]        = chg_q;
   end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: directed steps plus random stimulus
// compared against an angle-based behavioural model.
module tb_joy_dir_filter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [1:0] rotate = 2'd0;
   logic [7:0] dir_in = 8'h00;
   logic [7:0] u0_out, u3_out;
   logic [1:0] u0_chg, u3_chg;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ceper = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   joy_dir_filter #(.NUM_PLAYERS(2), .DB_TICKS(0), .DB_W(4)) u0 (
      .clk_sys (clk), .reset_n (reset_n), .ce (ce), .mode (mode),
      .rotate (rotate), .dir_in (dir_in), .dir_out (u0_out),
      .changed (u0_chg));

   joy_dir_filter #(.NUM_PLAYERS(2), .DB_TICKS(3), .DB_W(4)) u3 (
      .clk_sys (clk), .reset_n (reset_n), .ce (ce), .mode (mode),
      .rotate (rotate), .dir_in (dir_in), .dir_out (u3_out),
      .changed (u3_chg));

   // Model: directions as quarter-turn angles, selection as an index.
   logic [7:0] m_s1 [2], m_s2 [2], m_st [2];
   int         m_run [2][8];
   logic [3:0] m_dp [2][2], m_out [2][2];
   logic       m_chg [2][2];
   int         m_sel [2][2];
   logic [1:0] m_mp, m_rp;

   function automatic int quad(input int b);
      case (b)
         0: return 0;
         3: return 1;
         1: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int bitq(input int q);
      case (q)
         0: return 0;
         1: return 3;
         2: return 1;
         default: return 2;
      endcase
   endfunction

   function automatic logic [3:0] mrot(input logic [3:0] s, input logic [1:0] r);
      logic [3:0] d;
      int off;
      d = '0;
      off = (r == 2'd1) ? 3 : (r == 2'd2) ? 1 : (r == 2'd3) ? 2 : 0;
      for (int b = 0; b < 4; b++)
         if (s[b]) d[bitq((quad(b) + off) % 4)] = 1'b1;
      return d;
   endfunction

   function automatic int top(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input int k, input int T, input logic sc);
      logic [7:0] cur;
      logic [3:0] d, nx, pr;
      cur = (T == 0) ? m_s2[k] : m_st[k];
      if (T > 0) begin
         for (int b = 0; b < 8; b++) begin
            if (m_s2[k][b] == m_st[k][b]) m_run[k][b] = 0;
            else if (ce) begin
               m_run[k][b]++;
               if (m_run[k][b] == T) begin
                  m_st[k][b] = m_s2[k][b];
                  m_run[k][b] = 0;
               end
            end
         end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = dir_in;
      for (int p = 0; p < 2; p++) begin
         d = mrot(cur[4*p +: 4], rotate);
         if (sc) begin
            m_dp[k][p] = '0;
            m_sel[k][p] = -1;
            m_chg[k][p] = 1'b0;
         end else begin
            nx = d;
            if (mode == 2'd1) begin
               pr = d & ~m_dp[k][p];
               if (pr != 0) m_sel[k][p] = top(pr);
               else if ((m_sel[k][p] < 0 || !d[m_sel[k][p]]) && d != 0)
                  m_sel[k][p] = top(d);
            end else if (mode == 2'd3) begin
               if (m_sel[k][p] < 0 || !d[m_sel[k][p]]) m_sel[k][p] = top(d);
            end else begin
               m_sel[k][p] = -1;
            end
            if (mode == 2'd1 || mode == 2'd3)
               nx = (m_sel[k][p] >= 0) ? (d & (4'b1 << m_sel[k][p])) : 4'b0;
            if (mode == 2'd2) begin
               if (d[3] && d[2]) nx[3:2] = 2'b00;
               if (d[1] && d[0]) nx[1:0] = 2'b00;
            end
            m_chg[k][p] = (nx != m_out[k][p]);
            m_out[k][p] = nx;
            m_dp[k][p] = d;
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            m_s1[k] = '0; m_s2[k] = '0; m_st[k] = '0;
            for (int b = 0; b < 8; b++) m_run[k][b] = 0;
            for (int p = 0; p < 2; p++) begin
               m_dp[k][p] = '0; m_out[k][p] = '0;
               m_chg[k][p] = 1'b0; m_sel[k][p] = -1;
            end
         end
         m_mp = '0; m_rp = '0;
      end else begin
         model_step(0, 0, (mode != m_mp) || (rotate != m_rp));
         model_step(1, 3, (mode != m_mp) || (rotate != m_rp));
         m_mp = mode;
         m_rp = rotate;
      end
   end

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("u0_dir_out", u0_out, {m_out[0][1], m_out[0][0]});
         chk("u0_changed", {6'b0, u0_chg}, {6'b0, m_chg[0][1], m_chg[0][0]});
         chk("u3_dir_out", u3_out, {m_out[1][1], m_out[1][0]});
         chk("u3_changed", {6'b0, u3_chg}, {6'b0, m_chg[1][1], m_chg[1][0]});
         if (u3_chg[0]) pulses++;
         cyc++;
         ce = (ceper != 0) ? (cyc % 4 == 0) : ($urandom_range(2) == 0);
      end
   endtask

   initial begin
      tick(2);
      chk("reset_u0_out", u0_out, 8'h00);
      chk("reset_u3_out", u3_out, 8'h00);
      chk("reset_chg", {4'b0, u0_chg, u3_chg}, 8'h00);
      reset_n = 1'b1;

      // 4-way last-wins with fallback
      mode = 2'd1;
      tick(4);
      dir_in = 8'h01;
      tick(2); chk("lw_lat2", u0_out, 8'h00);
      tick(1); chk("lw_right", u0_out, 8'h01);
      chk("lw_right_chg", {6'b0, u0_chg}, 8'h01);
      tick(1); chk("lw_chg_drop", {6'b0, u0_chg}, 8'h00);
      tick(1);
      dir_in = 8'h09;
      tick(2); chk("lw_up_lat", u0_out, 8'h01);
      tick(1); chk("lw_up", u0_out, 8'h08);
      chk("lw_up_chg", {6'b0, u0_chg}, 8'h01);
      dir_in = 8'h01;
      tick(3); chk("lw_fallback", u0_out, 8'h01);
      chk("lw_fb_chg", {6'b0, u0_chg}, 8'h01);

      // 8-way opposite cancel
      dir_in = 8'h00; mode = 2'd2;
      tick(6);
      dir_in = 8'h0D; tick(3); chk("w8_udr", u0_out, 8'h01);
      dir_in = 8'h0F; tick(3); chk("w8_all", u0_out, 8'h00);
      dir_in = 8'h0B; tick(3); chk("w8_ulr", u0_out, 8'h08);

      // 4-way first-wins
      dir_in = 8'h00; mode = 2'd3;
      tick(6);
      dir_in = 8'h04; tick(3); chk("fw_down", u0_out, 8'h04);
      dir_in = 8'h0C; tick(3); chk("fw_keep", u0_out, 8'h04);
      dir_in = 8'h08; tick(3); chk("fw_up", u0_out, 8'h08);

      // rotation
      dir_in = 8'h00; mode = 2'd0; rotate = 2'd1;
      tick(6);
      dir_in = 8'h02; tick(3); chk("rot90_left", u0_out, 8'h08);
      rotate = 2'd3; tick(2); chk("rot180_left", u0_out, 8'h01);

      // debounce on the DB_TICKS=3 instance
      rotate = 2'd0; dir_in = 8'h00; ceper = 1;
      tick(40); chk("db_idle", u3_out, 8'h00);
      pulses = 0;
      dir_in = 8'h02; tick(8);
      dir_in = 8'h00; tick(20);
      chk("db_glitch", u3_out, 8'h00);
      chk("db_glitch_pulses", 8'(pulses), 8'h00);
      dir_in = 8'h02; tick(30);
      chk("db_hold", u3_out, 8'h02);
      chk("db_hold_pulses", 8'(pulses), 8'h01);

      // asynchronous reset mid-debounce
      dir_in = 8'h12; tick(5);
      chk("p1_right_u0", {4'b0, u0_out[7:4]}, 8'h01);
      #3 reset_n = 1'b0;
      #1;
      chk("async_u0", u0_out, 8'h00);
      chk("async_u3", u3_out, 8'h00);
      chk("async_chg", {4'b0, u0_chg, u3_chg}, 8'h00);
      tick(1);
      reset_n = 1'b1;
      tick(1); chk("post_rst_chg", {4'b0, u0_chg, u3_chg}, 8'h00);
      tick(5); chk("p1_redebounce", {4'b0, u3_out[7:4]}, 8'h00);
      tick(20); chk("p1_accepted", {4'b0, u3_out[7:4]}, 8'h01);

      // random stimulus against the model
      ceper = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(5) == 0) dir_in[$urandom_range(7)] ^= 1'b1;
         if ($urandom_range(99) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(119) == 0) rotate = 2'($urandom_range(3));
         if ($urandom_range(599) == 0) begin
            #2 reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
